// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS.CC timekeeper producing a packed-BCD display word.
// Divides clk down to a centisecond tick; supports run/pause, clear and paused hour/minute adjust.
module bcd_time_counter #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        clear,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [31:0] display,
  output logic        tick,
  output logic        day_wrap
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc, presc_n;
  logic [31:0]   disp_n;
  logic          tick_n, wrap_n;
  logic          advance;
  logic [8:0]    cs_inc, sec_inc, min_inc, hr_inc;

  // Single digit step: returns {carry, next digit}, wrapping at top.
  function automatic logic [4:0] inc_digit(input logic [3:0] d, input logic [3:0] top);
    if (d == top) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // Two-digit BCD step with tens wrapping at tens_top; returns {carry, tens, units}.
  function automatic logic [8:0] inc_pair(input logic [7:0] v, input logic [3:0] tens_top);
    logic [4:0] u, t;
    u = inc_digit(v[3:0], 4'd9);
    if (!u[4]) return {1'b0, v[7:4], u[3:0]};
    t = inc_digit(v[7:4], tens_top);
    return {t[4], t[3:0], u[3:0]};
  endfunction

  // Hours roll 23 -> 00; returns {wrap, tens, units}.
  function automatic logic [8:0] inc_hr(input logic [7:0] h);
    if (h == 8'h23)       return {1'b1, 8'h00};
    if (h[3:0] == 4'd9)   return {1'b0, h[7:4] + 4'd1, 4'd0};
    return {1'b0, h[7:4], h[3:0] + 4'd1};
  endfunction

  assign advance = run && (presc == PW'(DIV - 1));
  assign cs_inc  = inc_pair(display[7:0],   4'd9);
  assign sec_inc = inc_pair(display[15:8],  4'd5);
  assign min_inc = inc_pair(display[23:16], 4'd5);
  assign hr_inc  = inc_hr(display[31:24]);

  // Next-state: clear beats advance/adjust; adjust only while paused.
  always_comb begin
    disp_n  = display;
    presc_n = presc;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    if (clear) begin
      disp_n  = '0;
      presc_n = '0;
    end else if (run) begin
      if (advance) begin
        presc_n      = '0;
        tick_n       = 1'b1;
        disp_n[7:0]  = cs_inc[7:0];
        if (cs_inc[8]) begin
          disp_n[15:8] = sec_inc[7:0];
          if (sec_inc[8]) begin
            disp_n[23:16] = min_inc[7:0];
            if (min_inc[8]) begin
              disp_n[31:24] = hr_inc[7:0];
              wrap_n        = hr_inc[8];
            end
          end
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end else begin
      if (inc_min)  disp_n[23:16] = min_inc[7:0];
      if (inc_hour) disp_n[31:24] = hr_inc[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      display  <= '0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      presc    <= presc_n;
      display  <= disp_n;
      tick     <= tick_n;
      day_wrap <= wrap_n;
    end
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Timekeeping core that produces the 32-bit packed-BCD time word driving the eight-digit seven-segment display stage. It divides the system clock down to a 1/100 s tick and maintains a 24-hour clock as HH:MM:SS.CC (hours, minutes, seconds, centiseconds), one BCD digit per nibble. It provides run/pause, synchronous clear, and manual hour/minute adjustment while paused.

## Interface

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond tick rate. DIV = CLK_FREQ/TICK_HZ; DIV must be ≥ 2 and exact.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = count, 0 = paused.
- clear  input  1  synchronous; zeroes time and prescaler.
- inc_min  input  1  single-cycle pulse; minute +1 while paused.
- inc_hour  input  1  single-cycle pulse; hour +1 while paused.
- display  output  32  packed BCD; [31:28] hour tens, [27:24] hour units, [23:20] minute tens, [19:16] minute units, [15:12] second tens, [11:8] second units, [7:4] centisecond tens, [3:0] centisecond units.
- tick  output  1  registered pulse, high for one cycle when display has just advanced by 1 cs.
- day_wrap  output  1  registered pulse, high for one cycle when display has just rolled 23:59:59.99 → 00:00:00.00.

## Operation

- Prescaler: counter, width ceil(log2(DIV)). Counts 0..DIV-1 while run=1 and clear=0. Holds its value while run=0; pausing does not discard partial ticks.
- Advance event: the edge where run=1 and prescaler=DIV-1. Prescaler goes to 0 and the time increments by 1 cs.
- BCD carry chain, evaluated in one cycle:
  - cs units 9→0 carries to cs tens; cs tens 9→0 carries to seconds.
  - sec units 9→0 carries to sec tens; sec tens 5→0 carries to minutes.
  - Minutes use the same 0–9 / 0–5 rule and carry to hours.
  - Hours: units 9→0 increments the tens digit; 23 → 00 and raises day_wrap.
- Digit legality: no digit ever leaves its range (cs 00–99, sec/min 00–59, hr 00–23). Nibble values A–F never appear.
- Adjust, accepted only when run=0:
  - inc_min: minutes +1 mod 60. No carry into hours; seconds and cs unchanged.
  - inc_hour: hours +1 mod 24. day_wrap is not raised.
  - Both in the same cycle: both apply.
  - Ignored while run=1.
- Priority, highest first: rst > clear > advance/adjust. clear in the same cycle as an advance wins; tick stays 0.

## Timing

- Reset values: display = 32'h0000_0000, tick = 0, day_wrap = 0, prescaler = 0.
- Reset mid-count takes effect immediately (asynchronous). Counting resumes on the first edge after rst deasserts, if run=1.
- Counting from prescaler=0 with run held at 1: first display change DIV cycles later. tick and the new display appear on the same cycle, directly after the advance edge.
- tick period while running: exactly DIV cycles. tick is never high on two consecutive cycles.
- day_wrap coincides with the tick of the wrap advance.
- inc_min / inc_hour: display updates on the edge that samples the pulse, so latency is 1 cycle. Held high N cycles = N increments.
- clear: display = 0 and prescaler = 0 one edge after it is sampled. While clear is held, display stays 0 regardless of run.

## Test plan

Use CLK_FREQ=1000 and TICK_HZ=100, giving DIV=10.

- Reset, then run=1 for 10 cycles → display 32'h0000_0001 with tick high for exactly one cycle; after 1000 cycles → 32'h0000_0100.
- Preload 23:59:59.98 via clear plus inc_hour×23 and inc_min×59, then let cs count to 98; run 20 cycles → display 32'h2359_5999, then 32'h0000_0000 with day_wrap and tick high on the same cycle.
- Paused at 09:59:xx: inc_hour → 32'h10…; at hour 23, inc_hour → 00 with day_wrap=0; at minute 59, inc_min → 00 with hours unchanged.
- run=1 with inc_min pulsed → display unchanged apart from normal counting.
- Run 5 cycles, run=0 for 50 cycles, run=1 → first tick after 5 more cycles, confirming the prescaler held its value.
- clear asserted on the same cycle as an advance → display 0, tick 0. rst asserted mid-count → display 0 asynchronously, before the next clk edge.
